noc_target_responder: RTL and testbench

Target-side network interface that terminates read/write request packets arriving from the NoC, drives them into a local memory/slave port, and returns one single-flit response packet per request to the originating node. It sits between a mesh router's local port and a memory bank or slave. It is the responder counterpart of the PE-side initiator NIC, using the `noc_flit_t`, `pkt_type_t` and `qos_level_t` types from `noc_packet.sv`.

---
 rtl/noc_target_responder.sv | 273 +++++++++++++++++++++++++++
 tb/tb_noc_target_responder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_target_responder.sv
// ============================================================================
// Module  : noc_target_responder
// Brief   : Target-side NIC that turns NoC read/write requests into local
//           memory transactions and returns one response flit per request.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package noc_packet_pkg;
    typedef enum logic [2:0] {
        PKT_READ_REQ   = 3'd0,
        PKT_WRITE_REQ  = 3'd1,
        PKT_READ_RESP  = 3'd2,
        PKT_WRITE_RESP = 3'd3,
        PKT_MSG        = 3'd4
    } pkt_type_t;

    typedef enum logic [1:0] {
        QOS_LOW    = 2'd0,
        QOS_NORMAL = 2'd1,
        QOS_HIGH   = 2'd2,
        QOS_URGENT = 2'd3
    } qos_level_t;

    typedef struct packed {
        logic         head;
        logic         tail;
        pkt_type_t    pkt_type;
        logic [3:0]   src_x;
        logic [3:0]   src_y;
        logic [3:0]   dst_x;
        logic [3:0]   dst_y;
        logic [7:0]   pkt_id;
        qos_level_t   qos;
        logic [3:0]   length;
        logic         multicast;
        logic [255:0] data;
    } noc_flit_t;

    typedef struct packed {
        logic [3:0]   src_x;
        logic [3:0]   src_y;
        logic [7:0]   pkt_id;
        qos_level_t   qos;
        logic         we;
        logic [63:0]  addr;
        logic [2:0]   size;
        logic [255:0] wdata;
    } req_entry_t;

    typedef struct packed {
        logic [3:0]   src_x;
        logic [3:0]   src_y;
        logic [7:0]   pkt_id;
        qos_level_t   qos;
        logic         we;
    } tag_entry_t;
endpackage

module noc_target_responder
    import noc_packet_pkg::*;
#(
    parameter int NODE_X          = 0,
    parameter int NODE_Y          = 0,
    parameter int REQ_DEPTH       = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  noc_flit_t      noc_flit_in,
    input  logic           noc_valid_in,
    output logic           noc_ready_out,
    output noc_flit_t      noc_flit_out,
    output logic           noc_valid_out,
    input  logic           noc_ready_in,
    output logic           mem_req_valid,
    input  logic           mem_req_ready,
    output logic           mem_we,
    output logic [63:0]    mem_addr,
    output logic [2:0]     mem_size,
    output logic [255:0]   mem_wdata,
    input  logic           mem_rsp_valid,
    output logic           mem_rsp_ready,
    input  logic [255:0]   mem_rsp_data,
    output logic [31:0]    requests_served,
    output logic [31:0]    dropped_flits,
    output logic           busy
);
    localparam int REQ_AW = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
    localparam int TAG_AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int REQ_CW = $clog2(REQ_DEPTH + 1);
    localparam int TAG_CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [3:0] C_NODE_X = 4'(NODE_X);
    localparam logic [3:0] C_NODE_Y = 4'(NODE_Y);

    typedef enum logic [0:0] {
        RX_IDLE  = 1'b0,
        RX_WDATA = 1'b1
    } rx_state_t;

    rx_state_t          state_q, state_d;
    req_entry_t         hdr_q, hdr_d;
    req_entry_t         req_mem_q [REQ_DEPTH];
    tag_entry_t         tag_mem_q [MAX_OUTSTANDING];
    logic [REQ_AW-1:0]  req_wr_q, req_wr_d, req_rd_q, req_rd_d;
    logic [REQ_CW-1:0]  req_cnt_q, req_cnt_d;
    logic [TAG_AW-1:0]  tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [TAG_CW-1:0]  tag_cnt_q, tag_cnt_d;
    noc_flit_t          out_q, out_d;
    logic               out_vld_q, out_vld_d;
    logic [31:0]        served_q, served_d, dropped_q, dropped_d;

    logic               w_rx_accept, w_rx_drop;
    logic               w_req_push, w_req_pop, w_tag_push, w_tag_pop;
    logic               w_req_full, w_req_empty, w_tag_full, w_tag_empty;
    req_entry_t         w_req_push_data, w_req_head;
    tag_entry_t         w_tag_push_data, w_tag_head;
    logic               w_unused;

    assign w_req_full  = (req_cnt_q == REQ_CW'(REQ_DEPTH));
    assign w_req_empty = (req_cnt_q == '0);
    assign w_tag_full  = (tag_cnt_q == TAG_CW'(MAX_OUTSTANDING));
    assign w_tag_empty = (tag_cnt_q == '0);

    assign noc_ready_out = !w_req_full;
    assign w_rx_accept   = noc_valid_in && noc_ready_out;

    always_comb begin : rx_fsm
        state_d         = state_q;
        hdr_d           = hdr_q;
        w_req_push      = 1'b0;
        w_rx_drop       = 1'b0;
        w_req_push_data = '0;
        w_req_push_data.src_x  = noc_flit_in.src_x;
        w_req_push_data.src_y  = noc_flit_in.src_y;
        w_req_push_data.pkt_id = noc_flit_in.pkt_id;
        w_req_push_data.qos    = noc_flit_in.qos;
        w_req_push_data.addr   = noc_flit_in.data[63:0];
        w_req_push_data.size   = noc_flit_in.data[66:64];
        case (state_q)
            RX_IDLE: begin
                if (w_rx_accept) begin
                    if (noc_flit_in.head && noc_flit_in.tail &&
                        noc_flit_in.pkt_type == PKT_READ_REQ) begin
                        w_req_push = 1'b1;
                    end else if (noc_flit_in.head && !noc_flit_in.tail &&
                                 noc_flit_in.pkt_type == PKT_WRITE_REQ) begin
                        hdr_d   = w_req_push_data;
                        state_d = RX_WDATA;
                    end else begin
                        w_rx_drop = 1'b1;
                    end
                end
            end
            RX_WDATA: begin
                if (w_rx_accept) begin
                    state_d = RX_IDLE;
                    if (!noc_flit_in.head && noc_flit_in.tail) begin
                        w_req_push            = 1'b1;
                        w_req_push_data       = hdr_q;
                        w_req_push_data.we    = 1'b1;
                        w_req_push_data.wdata = noc_flit_in.data;
                    end else begin
                        w_rx_drop = 1'b1;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // Issue stage: the tag FIFO bounds how many requests memory may hold.
    assign w_req_head    = req_mem_q[req_rd_q];
    assign mem_req_valid = !w_req_empty && !w_tag_full;
    assign mem_we        = w_req_head.we;
    assign mem_addr      = w_req_head.addr;
    assign mem_size      = w_req_head.size;
    assign mem_wdata     = w_req_head.wdata;
    assign w_req_pop     = mem_req_valid && mem_req_ready;
    assign w_tag_push    = w_req_pop;
    assign w_tag_push_data = '{src_x: w_req_head.src_x, src_y: w_req_head.src_y,
                               pkt_id: w_req_head.pkt_id, qos: w_req_head.qos,
                               we: w_req_head.we};

    assign w_tag_head    = tag_mem_q[tag_rd_q];
    assign mem_rsp_ready = !out_vld_q || noc_ready_in;
    assign w_tag_pop     = mem_rsp_valid && mem_rsp_ready;

    always_comb begin : ptr_next
        req_wr_d  = req_wr_q;
        req_rd_d  = req_rd_q;
        tag_wr_d  = tag_wr_q;
        tag_rd_d  = tag_rd_q;
        if (w_req_push) req_wr_d = (req_wr_q == REQ_AW'(REQ_DEPTH - 1)) ? '0 : req_wr_q + 1'b1;
        if (w_req_pop)  req_rd_d = (req_rd_q == REQ_AW'(REQ_DEPTH - 1)) ? '0 : req_rd_q + 1'b1;
        if (w_tag_push) tag_wr_d = (tag_wr_q == TAG_AW'(MAX_OUTSTANDING - 1)) ? '0 : tag_wr_q + 1'b1;
        if (w_tag_pop)  tag_rd_d = (tag_rd_q == TAG_AW'(MAX_OUTSTANDING - 1)) ? '0 : tag_rd_q + 1'b1;
        req_cnt_d = req_cnt_q + REQ_CW'(w_req_push) - REQ_CW'(w_req_pop);
        tag_cnt_d = tag_cnt_q + TAG_CW'(w_tag_push) - TAG_CW'(w_tag_pop);
    end

    always_comb begin : rsp_next
        out_d     = out_q;
        out_vld_d = out_vld_q;
        if (w_tag_pop) begin
            out_vld_d       = 1'b1;
            out_d           = '0;
            out_d.head      = 1'b1;
            out_d.tail      = 1'b1;
            out_d.pkt_type  = w_tag_head.we ? PKT_WRITE_RESP : PKT_READ_RESP;
            out_d.src_x     = C_NODE_X;
            out_d.src_y     = C_NODE_Y;
            out_d.dst_x     = w_tag_head.src_x;
            out_d.dst_y     = w_tag_head.src_y;
            out_d.pkt_id    = w_tag_head.pkt_id;
            out_d.qos       = w_tag_head.qos;
            out_d.length    = 4'd1;
            out_d.data      = w_tag_head.we ? '0 : mem_rsp_data;
        end else if (noc_ready_in) begin
            out_vld_d = 1'b0;
        end
        served_d  = served_q + 32'(out_vld_q && noc_ready_in);
        dropped_d = dropped_q + 32'(w_rx_drop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RX_IDLE;
            hdr_q     <= '0;
            req_wr_q  <= '0;
            req_rd_q  <= '0;
            req_cnt_q <= '0;
            tag_wr_q  <= '0;
            tag_rd_q  <= '0;
            tag_cnt_q <= '0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
            served_q  <= '0;
            dropped_q <= '0;
        end else begin
            state_q   <= state_d;
            hdr_q     <= hdr_d;
            req_wr_q  <= req_wr_d;
            req_rd_q  <= req_rd_d;
            req_cnt_q <= req_cnt_d;
            tag_wr_q  <= tag_wr_d;
            tag_rd_q  <= tag_rd_d;
            tag_cnt_q <= tag_cnt_d;
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
            served_q  <= served_d;
            dropped_q <= dropped_d;
        end
    end

    // Storage arrays need no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_req_push) req_mem_q[req_wr_q] <= w_req_push_data;
        if (w_tag_push) tag_mem_q[tag_wr_q] <= w_tag_push_data;
    end

    assign noc_flit_out    = out_q;
    assign noc_valid_out   = out_vld_q;
    assign requests_served = served_q;
    assign dropped_flits   = dropped_q;
    assign busy = !w_req_empty || !w_tag_empty || (state_q != RX_IDLE) || out_vld_q;

    assign w_unused = ^{noc_flit_in.dst_x, noc_flit_in.dst_y, noc_flit_in.length,
                        noc_flit_in.multicast, hdr_q.we, hdr_q.wdata};

endmodule

`default_nettype wire

// File: tb/tb_noc_target_responder.sv
// ============================================================================
// Module  : tb_noc_target_responder
// Brief   : Directed self-checking bench with an in-order memory model and
//           a response scoreboard for noc_target_responder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_noc_target_responder;
    import noc_packet_pkg::*;

    localparam int NODE_X          = 3;
    localparam int NODE_Y          = 2;
    localparam int REQ_DEPTH       = 4;
    localparam int MAX_OUTSTANDING = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    noc_flit_t      noc_flit_in = '0;
    logic           noc_valid_in = 1'b0;
    logic           noc_ready_out;
    noc_flit_t      noc_flit_out;
    logic           noc_valid_out;
    logic           noc_ready_in = 1'b1;
    logic           mem_req_valid;
    logic           mem_req_ready = 1'b1;
    logic           mem_we;
    logic [63:0]    mem_addr;
    logic [2:0]     mem_size;
    logic [255:0]   mem_wdata;
    logic           mem_rsp_valid = 1'b0;
    logic           mem_rsp_ready;
    logic [255:0]   mem_rsp_data = '0;
    logic [31:0]    requests_served;
    logic [31:0]    dropped_flits;
    logic           busy;

    noc_target_responder #(
        .NODE_X(NODE_X), .NODE_Y(NODE_Y),
        .REQ_DEPTH(REQ_DEPTH), .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .noc_flit_in(noc_flit_in), .noc_valid_in(noc_valid_in), .noc_ready_out(noc_ready_out),
        .noc_flit_out(noc_flit_out), .noc_valid_out(noc_valid_out), .noc_ready_in(noc_ready_in),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_size(mem_size), .mem_wdata(mem_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_data(mem_rsp_data),
        .requests_served(requests_served), .dropped_flits(dropped_flits), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         we;
        logic [63:0]  addr;
        logic [2:0]   size;
        logic [255:0] wdata;
    } mem_exp_t;

    noc_flit_t     exp_rsp[$];
    mem_exp_t      exp_mem[$];
    logic [255:0]  pend[$];
    int            n_checks = 0;
    int            n_pass   = 0;

    task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [255:0] rd_data(input logic [63:0] addr);
        return {4{addr ^ 64'hDEADBEEF_00000000}};
    endfunction

    function automatic noc_flit_t make_rsp(input int sx, input int sy, input int id,
                                           input int q, input logic we, input logic [255:0] d);
        noc_flit_t f;
        f = '0;
        f.head = 1'b1; f.tail = 1'b1;
        f.pkt_type = we ? PKT_WRITE_RESP : PKT_READ_RESP;
        f.src_x = 4'(NODE_X); f.src_y = 4'(NODE_Y);
        f.dst_x = 4'(sx); f.dst_y = 4'(sy);
        f.pkt_id = 8'(id); f.qos = qos_level_t'(q); f.length = 4'd1;
        f.data = d;
        return f;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_flit(input noc_flit_t f);
        logic acc;
        int   n;
        acc = 1'b0; n = 0;
        noc_flit_in = f; noc_valid_in = 1'b1;
        while (!acc && n < 500) begin
            #4;
            acc = noc_ready_out;
            @(negedge clk);
            n++;
        end
        noc_valid_in = 1'b0; noc_flit_in = '0;
        check("send_accept", acc, 1);
    endtask

    function automatic noc_flit_t make_req(input pkt_type_t t, input logic h, input logic tl,
                                           input int sx, input int sy, input int id, input int q,
                                           input logic [255:0] d);
        noc_flit_t f;
        f = '0;
        f.head = h; f.tail = tl; f.pkt_type = t;
        f.src_x = 4'(sx); f.src_y = 4'(sy);
        f.dst_x = 4'(NODE_X); f.dst_y = 4'(NODE_Y);
        f.pkt_id = 8'(id); f.qos = qos_level_t'(q); f.length = tl ? 4'd1 : 4'd2;
        f.data = d;
        return f;
    endfunction

    task automatic send_read(input int sx, input int sy, input int id, input int q,
                             input logic [63:0] addr, input logic [2:0] size);
        exp_mem.push_back('{we: 1'b0, addr: addr, size: size, wdata: '0});
        exp_rsp.push_back(make_rsp(sx, sy, id, q, 1'b0, rd_data(addr)));
        send_flit(make_req(PKT_READ_REQ, 1'b1, 1'b1, sx, sy, id, q, {189'd0, size, addr}));
    endtask

    task automatic send_write(input int sx, input int sy, input int id, input int q,
                              input logic [63:0] addr, input logic [2:0] size, input logic [255:0] wd);
        exp_mem.push_back('{we: 1'b1, addr: addr, size: size, wdata: wd});
        exp_rsp.push_back(make_rsp(sx, sy, id, q, 1'b1, '0));
        send_flit(make_req(PKT_WRITE_REQ, 1'b1, 1'b0, sx, sy, id, q, {189'd0, size, addr}));
        send_flit(make_req(PKT_WRITE_REQ, 1'b0, 1'b1, sx, sy, id, q, wd));
    endtask

    task automatic wait_idle(input int budget);
        for (int n = 0; n < budget; n++) begin
            if (exp_rsp.size() == 0 && exp_mem.size() == 0 && !busy) break;
            @(negedge clk);
        end
        check("drain", {busy, 32'(exp_rsp.size()), 32'(exp_mem.size())}, 0);
    endtask

    // Memory model (one-cycle latency, in order) plus response scoreboard.
    initial begin : mem_and_monitor
        logic         prev_out_stall, prev_req_stall;
        noc_flit_t    prev_flit, e;
        logic [63:0]  prev_addr;
        mem_exp_t     m;
        prev_out_stall = 1'b0; prev_req_stall = 1'b0; prev_flit = '0; prev_addr = '0;
        forever begin
            @(negedge clk);
            if (rst_n && pend.size() > 0) begin
                mem_rsp_valid = 1'b1; mem_rsp_data = pend[0];
            end else begin
                mem_rsp_valid = 1'b0; mem_rsp_data = '0;
            end
            #4;
            if (!rst_n) begin
                pend.delete();
                prev_out_stall = 1'b0; prev_req_stall = 1'b0;
            end else begin
                if (prev_out_stall)
                    check("out_hold", {noc_valid_out, noc_flit_out}, {1'b1, prev_flit});
                if (prev_req_stall)
                    check("req_hold", {mem_req_valid, mem_addr}, {1'b1, prev_addr});
                if (mem_req_valid && mem_req_ready) begin
                    if (exp_mem.size() == 0) begin
                        check("mem_unexpected", 320'(exp_mem.size()), 1);
                    end else begin
                        m = exp_mem.pop_front();
                        check("mem_req", {mem_we, mem_size, mem_addr}, {m.we, m.size, m.addr});
                        check("mem_wdata", mem_wdata, m.wdata);
                    end
                    pend.push_back(mem_we ? {256{1'b1}} : rd_data(mem_addr));
                end
                if (mem_rsp_valid && mem_rsp_ready) void'(pend.pop_front());
                if (noc_valid_out && noc_ready_in) begin
                    if (exp_rsp.size() == 0) begin
                        check("rsp_unexpected", 320'(exp_rsp.size()), 1);
                    end else begin
                        e = exp_rsp.pop_front();
                        check("rsp_flit", noc_flit_out, e);
                    end
                end
                prev_out_stall = noc_valid_out && !noc_ready_in;
                prev_flit      = noc_flit_out;
                prev_req_stall = mem_req_valid && !mem_req_ready;
                prev_addr      = mem_addr;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready_out", noc_ready_out, 1);
        check("rst_outputs", {noc_valid_out, noc_flit_out, mem_req_valid, mem_rsp_ready, busy},
              {1'b0, 292'd0, 1'b0, 1'b1, 1'b0});
        check("rst_counters", {requests_served, dropped_flits}, 0);

        // Single read with latency checks
        send_read(2, 1, 8'h05, 1, 64'h40, 3'd5);
        check("lat_req_valid", mem_req_valid, 1);
        repeat (2) @(negedge clk);
        check("lat_rsp_valid", noc_valid_out, 1);
        wait_idle(50);
        check("served_1", requests_served, 1);

        // Two-flit write, qos echoed, data zero in response
        send_write(1, 3, 8'h22, 2, 64'h80, 3'd3, 256'h1234);
        wait_idle(50);
        check("served_2", requests_served, 2);

        // Back-pressure from the router fills every queue
        noc_ready_in = 1'b0;
        fork
            begin
                for (int i = 0; i < REQ_DEPTH + MAX_OUTSTANDING + 2; i++)
                    send_read(4, 5, 8'h10 + i, i % 4, 64'h1000 + 64'(i) * 64, 3'd5);
            end
            begin
                repeat (40) @(negedge clk);
                check("bp_ready_low", noc_ready_out, 0);
                check("bp_valid_held", noc_valid_out, 1);
                noc_ready_in = 1'b1;
            end
        join
        wait_idle(200);
        check("served_3", requests_served, 12);

        // Malformed traffic: stray body flit, then head interrupting a write
        send_flit(make_req(PKT_WRITE_REQ, 1'b0, 1'b1, 1, 1, 8'h30, 0, 256'hBAD));
        send_flit(make_req(PKT_WRITE_REQ, 1'b1, 1'b0, 1, 1, 8'h31, 0, 256'h200));
        send_flit(make_req(PKT_READ_REQ, 1'b1, 1'b1, 1, 1, 8'h32, 0, 256'h240));
        repeat (3) @(negedge clk);
        check("dropped_2", dropped_flits, 2);
        check("drop_idle", {busy, mem_req_valid}, 0);

        // Memory stall with three reads queued
        mem_req_ready = 1'b0;
        send_read(6, 7, 8'h40, 3, 64'h100, 3'd2);
        send_read(6, 7, 8'h41, 0, 64'h140, 3'd2);
        send_read(6, 7, 8'h42, 1, 64'h180, 3'd2);
        repeat (10) @(negedge clk);
        check("stall_req", {mem_req_valid, mem_addr}, {1'b1, 64'h100});
        mem_req_ready = 1'b1;
        wait_idle(100);
        check("served_total", requests_served, 15);

        // Reset between a write's head and body, with a read still queued
        mem_req_ready = 1'b0;
        send_read(2, 2, 8'h50, 0, 64'h300, 3'd1);
        send_flit(make_req(PKT_WRITE_REQ, 1'b1, 1'b0, 2, 2, 8'h51, 0, 256'h340));
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        exp_rsp.delete();
        exp_mem.delete();
        mem_req_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_rst_outputs", {noc_ready_out, noc_valid_out, noc_flit_out, mem_req_valid,
                                  mem_rsp_ready, busy},
              {1'b1, 1'b0, 292'd0, 1'b0, 1'b1, 1'b0});
        check("mid_rst_counters", {requests_served, dropped_flits}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        send_read(5, 4, 8'h60, 2, 64'h3C0, 3'd4);
        wait_idle(50);
        check("post_rst_served", {requests_served, dropped_flits}, {32'd1, 32'd0});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
